// File: rtl/periph_apb_pkg.sv
// ============================================================================
// Module   : periph_apb_pkg
// Purpose  : Shared state encoding and AXI response codes for the APB manager.
// Revision : 1.0
// ============================================================================
`default_nettype none

package periph_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/periph_apb_timeout.sv
// ============================================================================
// Module   : periph_apb_timeout
// Purpose  : ACCESS-phase wait counter; expire_o flags the TIMEOUT_CYCLES-th
//            enabled cycle. Used only when PERIPH_AXIL2APB_TIMEOUT_EN is set.
// Revision : 1.0
// ============================================================================
`default_nettype none

module periph_apb_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count <= '0;
        end else if (clear_i) begin
            count <= '0;
        end else if (enable_i && (count != CNT_WIDTH'(TIMEOUT_CYCLES))) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    // count holds the number of ACCESS cycles already spent before this one
    assign expire_o = enable_i && (count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/periph_axil2apb_mgr.sv
// ============================================================================
// Module   : periph_axil2apb_mgr
// Purpose  : AXI4-Lite to APB manager, one transfer outstanding, read/write
//            alternation on ties. Optional timeout: PERIPH_AXIL2APB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module periph_axil2apb_mgr
    import periph_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    output logic [1:0]              bresp_o,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pready_i,
    input  logic                    psuberr_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    apb_state_t              state;
    apb_state_t              state_next;
    logic                    last_was_write;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   strb_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    wr_cand;
    logic                    rd_cand;
    logic                    grant_wr;
    logic                    grant_rd;
    logic                    timeout_hit;

    // Ties go to whichever direction was not granted last
    always_comb begin
        wr_cand  = awvalid_i & wvalid_i;
        rd_cand  = arvalid_i;
        grant_wr = (state == IDLE) & rstn_i & wr_cand & (~rd_cand | ~last_was_write);
        grant_rd = (state == IDLE) & rstn_i & rd_cand & (~wr_cand | last_was_write);
    end

`ifdef PERIPH_AXIL2APB_TIMEOUT_EN
    periph_apb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clear_i  (state == SETUP),
        .enable_i (state == ACCESS),
        .expire_o (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_wr || grant_rd) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (pready_i || timeout_hit) state_next = RESP;
            RESP:    if (write_q ? bready_i : rready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_was_write <= 1'b0;
            write_q        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            strb_q         <= '0;
            err_q          <= 1'b0;
            rdata_q        <= '0;
        end else begin
            if (grant_wr || grant_rd) begin
                last_was_write <= grant_wr;
                write_q        <= grant_wr;
                addr_q         <= grant_wr ? awaddr_i : araddr_i;
                wdata_q        <= grant_wr ? wdata_i : '0;
                strb_q         <= grant_wr ? wstrb_i : '0;
            end
            // A timeout completion is treated as an error with no data
            if ((state == ACCESS) && (pready_i || timeout_hit)) begin
                err_q   <= ~pready_i | psuberr_i;
                rdata_q <= (pready_i && !psuberr_i) ? prdata_i : '0;
            end
        end
    end

    always_comb begin
        awready_o = grant_wr;
        wready_o  = grant_wr;
        arready_o = grant_rd;
        psel_o    = (state == SETUP) || (state == ACCESS);
        penable_o = (state == ACCESS);
        pwrite_o  = write_q;
        paddr_o   = addr_q;
        pwdata_o  = wdata_q;
        pstrb_o   = strb_q;
        bvalid_o  = (state == RESP) && write_q;
        rvalid_o  = (state == RESP) && !write_q;
        bresp_o   = (bvalid_o && err_q) ? RESP_SLVERR : RESP_OKAY;
        rresp_o   = (rvalid_o && err_q) ? RESP_SLVERR : RESP_OKAY;
        rdata_o   = rvalid_o ? rdata_q : '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_periph_axil2apb_mgr.sv
// ============================================================================
// Module   : tb_periph_axil2apb_mgr
// Purpose  : Directed and randomized self-checking bench for the APB manager.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_periph_axil2apb_mgr;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic          bready = 1'b0, rready = 1'b0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [DW-1:0] wdata = '0, prdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          pready = 1'b0, psuberr = 1'b0;

    logic          awready, wready, arready, bvalid, rvalid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata, pwdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [SW-1:0] pstrb;

    int total = 0;
    int bad   = 0;

    periph_axil2apb_mgr #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .awvalid_i (awvalid),
        .awready_o (awready),
        .awaddr_i  (awaddr),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .bvalid_o  (bvalid),
        .bready_i  (bready),
        .bresp_o   (bresp),
        .arvalid_i (arvalid),
        .arready_o (arready),
        .araddr_i  (araddr),
        .rvalid_o  (rvalid),
        .rready_i  (rready),
        .rdata_o   (rdata),
        .rresp_o   (rresp),
        .psel_o    (psel),
        .penable_o (penable),
        .pwrite_o  (pwrite),
        .paddr_o   (paddr),
        .pwdata_o  (pwdata),
        .pstrb_o   (pstrb),
        .prdata_i  (prdata),
        .pready_i  (pready),
        .psuberr_i (psuberr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a transfer is granted, spends one SETUP
    // cycle, stays in ACCESS until the completer is ready, then holds its
    // response until the AXI side accepts it.
    bit            m_busy = 0, m_last_w = 0, m_w = 0, m_done = 0, m_err = 0;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_rdata;
    logic [SW-1:0] m_strb;
    int            m_age = 0, m_acc = 0;

    initial begin : compare
        bit wc, rc, gw, gr;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_busy = 0;
                m_last_w = 0;
                chk("rst_ready", {awready, wready, arready}, 0);
                chk("rst_apb", {psel, penable, pwrite, paddr, pstrb}, 0);
                chk("rst_pwdata", pwdata, 0);
                chk("rst_resp", {bvalid, rvalid, bresp, rresp}, 0);
                chk("rst_rdata", rdata, 0);
            end else if (!m_busy) begin
                wc = awvalid && wvalid;
                rc = arvalid;
                gw = wc && (!rc || !m_last_w);
                gr = rc && (!wc || m_last_w);
                chk("idle_awready", awready, gw);
                chk("idle_wready", wready, gw);
                chk("idle_arready", arready, gr);
                chk("idle_apb", {psel, penable}, 0);
                chk("idle_valid", {bvalid, rvalid}, 0);
                chk("idle_rdata", rdata, 0);
                if (gw || gr) begin
                    m_busy   = 1;
                    m_w      = gw;
                    m_last_w = gw;
                    m_addr   = gw ? awaddr : araddr;
                    m_data   = wdata;
                    m_strb   = gw ? wstrb : '0;
                    m_age    = 0;
                    m_acc    = 0;
                    m_done   = 0;
                end
            end else begin
                m_age++;
                chk("busy_ready", {awready, wready, arready}, 0);
                if (!m_done) begin
                    chk("apb_psel", psel, 1);
                    chk("apb_penable", penable, m_age >= 2);
                    chk("apb_paddr", paddr, m_addr);
                    chk("apb_pwrite", pwrite, m_w);
                    chk("apb_pstrb", pstrb, m_strb);
                    if (m_w) chk("apb_pwdata", pwdata, m_data);
                    chk("apb_novalid", {bvalid, rvalid}, 0);
                    chk("apb_rdata0", rdata, 0);
                    if (m_age >= 2) begin
                        m_acc++;
                        if (pready) begin
                            m_done  = 1;
                            m_err   = psuberr;
                            m_rdata = psuberr ? '0 : prdata;
                        end
`ifdef PERIPH_AXIL2APB_TIMEOUT_EN
                        else if (m_acc == TO) begin
                            m_done  = 1;
                            m_err   = 1;
                            m_rdata = '0;
                        end
`endif
                    end
                end else begin
                    chk("resp_apb", {psel, penable}, 0);
                    chk("resp_bvalid", bvalid, m_w);
                    chk("resp_rvalid", rvalid, !m_w);
                    if (m_w) begin
                        chk("resp_bresp", bresp, m_err ? 2'b10 : 2'b00);
                        chk("resp_rdata_w", rdata, 0);
                    end else begin
                        chk("resp_rresp", rresp, m_err ? 2'b10 : 2'b00);
                        chk("resp_rdata", rdata, m_rdata);
                    end
                    if (m_w ? bready : rready) m_busy = 0;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready || arready) begin
                ok = 1;
                break;
            end
            next_cycle();
        end
        chk(name, ok, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin : driver
        bit       ok, hs_aw, hs_w, hs_ar;
        bit [3:0] seq;
        int       n;

        // Reset with requests pending: readies must stay low
        awvalid = 1; wvalid = 1; arvalid = 1;
        awaddr = 32'h1111_2222; araddr = 32'h3333_4444;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_lit_ready", {awready, wready, arready}, 3'b000);
        chk("rst_lit_psel", psel, 0);
        next_cycle();
        awvalid = 0; wvalid = 0; arvalid = 0;
        rstn = 1;
        next_cycle();

        // Zero-wait write
        awvalid = 1; wvalid = 1; awaddr = 32'h8f00_b004; wdata = 32'hA5A5_0001; wstrb = 4'hF;
        pready = 1; psuberr = 0; bready = 1; rready = 1;
        wait_grant("wr_grant", ok);
        chk("wr_is_write", awready, 1);
        next_cycle();
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("wr_n1_psel_pen", {psel, penable}, 2'b10);
        next_cycle();
        @(negedge clk);
        chk("wr_n2_penable", penable, 1);
        chk("wr_n2_pstrb", pstrb, 4'hF);
        chk("wr_n2_pwrite", pwrite, 1);
        chk("wr_n2_paddr", paddr, 32'h8f00_b004);
        next_cycle();
        @(negedge clk);
        chk("wr_n3_bvalid", bvalid, 1);
        chk("wr_n3_bresp", bresp, 2'b00);
        next_cycle();

        // Read with three wait states
        arvalid = 1; araddr = 32'h8f00_0800; pready = 0; prdata = 32'h1234_5678;
        wait_grant("rd_grant", ok);
        chk("rd_is_read", arready, 1);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 1) arvalid = 0;
            pready = (k == 5);
            @(negedge clk);
            if (k <= 5) begin
                chk("rd_wait_psel", psel, 1);
                chk("rd_wait_pstrb", pstrb, 0);
                chk("rd_wait_rvalid", rvalid, 0);
            end else begin
                chk("rd_n6_rvalid", rvalid, 1);
                chk("rd_n6_rdata", rdata, 32'h1234_5678);
                chk("rd_n6_rresp", rresp, 2'b00);
            end
        end
        next_cycle();

        // Unmapped read: decoder reports an error
        arvalid = 1; araddr = 32'h8f00_e000; pready = 1; psuberr = 1; prdata = 32'hDEAD_BEEF;
        wait_grant("err_grant", ok);
        next_cycle();
        arvalid = 0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("err_rvalid", rvalid, 1);
        chk("err_rresp", rresp, 2'b10);
        chk("err_rdata", rdata, 0);
        next_cycle();
        psuberr = 0;

        // Constant contention: grants must alternate starting with a write
        awvalid = 1; wvalid = 1; arvalid = 1; pready = 1; bready = 1; rready = 1;
        n = 0;
        seq = '0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (awready) begin seq[n] = 1'b1; n++; end
            else if (arready) begin seq[n] = 1'b0; n++; end
            next_cycle();
            awaddr = $urandom; araddr = $urandom; wdata = $urandom;
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("alt_count", n, 4);
        for (int i = 0; i < 4; i++) chk("alt_order", seq[i], (i % 2) == 0);
        repeat (4) next_cycle();

        // Write response back-pressure
        awvalid = 1; wvalid = 1; awaddr = 32'h8f00_0010; wdata = 32'h0BAD_F00D; wstrb = 4'h3;
        bready = 0; pready = 1; psuberr = 0;
        wait_grant("bp_grant", ok);
        next_cycle();
        awvalid = 0; wvalid = 0; arvalid = 1; araddr = 32'h8f00_0020;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1; break; end
            next_cycle();
        end
        chk("bp_bvalid_seen", ok, 1);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk);
            chk("bp_hold_bvalid", bvalid, 1);
            chk("bp_hold_bresp", bresp, 2'b00);
            chk("bp_no_grant", {arready, awready}, 2'b00);
        end
        next_cycle();
        bready = 1;
        @(negedge clk);
        chk("bp_accept_bvalid", bvalid, 1);
        next_cycle();
        @(negedge clk);
        chk("bp_idle_grant", arready, 1);
        next_cycle();
        arvalid = 0; rready = 1;
        repeat (5) next_cycle();

        // Reset during ACCESS
        arvalid = 1; araddr = 32'h8f00_0040; pready = 0;
        wait_grant("rst_grant", ok);
        next_cycle();
        arvalid = 0;
        next_cycle();
        @(negedge clk);
        chk("rst_in_access", penable, 1);
        @(posedge clk);
        #3;
        rstn = 0;
        #1;
        chk("rst_async_drop", {psel, penable}, 2'b00);
        next_cycle();
        next_cycle();
        rstn = 1;
        pready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_resp", rvalid, 0);
            next_cycle();
        end

        // Randomized traffic under random APB waits and AXI back-pressure
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_ar = arvalid && arready;
            next_cycle();
            if (!awvalid || hs_aw) begin
                awvalid = ($urandom_range(0, 99) < 50);
                awaddr  = $urandom;
            end
            if (!wvalid || hs_w) begin
                wvalid = ($urandom_range(0, 99) < 50);
                wdata  = $urandom;
                wstrb  = 4'($urandom_range(0, 15));
            end
            if (!arvalid || hs_ar) begin
                arvalid = ($urandom_range(0, 99) < 50);
                araddr  = $urandom;
            end
            pready  = ($urandom_range(0, 99) < 40);
            psuberr = ($urandom_range(0, 3) == 0);
            prdata  = $urandom;
            bready  = ($urandom_range(0, 99) < 60);
            rready  = ($urandom_range(0, 99) < 60);
        end

        // Drain: no new requests, everything completes at once
        @(negedge clk);
        next_cycle();
        awvalid = 0; wvalid = 0; arvalid = 0;
        pready = 1; bready = 1; rready = 1;
        repeat (20) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
